// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: definitions shared by the data-memory responder and its lane unit.
//   XLEN         - datapath and address width
//   F3_*         - RV32I load/store funct3 width codes
//   state_e      - responder FSM state encoding (IDLE / WAIT / RESP)
package rv_mem_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_lane_unit.sv
// dmem_lane_unit: combinational byte-lane steering for the data memory.
// Store side: byte-enable and lane-replicated write data for SB/SH/SW.
// Load side : byte/half/word extraction from the addressed RAM word with
//             sign or zero extension.
// access_err flags an illegal funct3 for the given direction; when the
// DMEM_MISALIGN_TRAP_EN macro is defined it also flags misaligned halfword
// and word accesses. Without that macro, misaligned offsets are truncated.
// When access_err is set, byte_en and load_data are forced to zero.
// Ports:
//   is_store   in  1     access direction (1 = store)
//   funct3     in  3     width code
//   byte_off   in  2     addr[1:0] of the access
//   wdata      in  XLEN  raw store data
//   rword      in  XLEN  current contents of the addressed RAM word
//   byte_en    out 4     per-byte write enable
//   wword      out XLEN  replicated store data
//   load_data  out XLEN  extended load result
//   access_err out 1     access must be rejected
module dmem_lane_unit
  import rv_mem_pkg::*;
(
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [1:0]      byte_off,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rword,
  output logic [3:0]      byte_en,
  output logic [XLEN-1:0] wword,
  output logic [XLEN-1:0] load_data,
  output logic            access_err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  always_comb begin
    byte_sel   = 8'h00;
    half_sel   = 16'h0000;
    byte_en    = 4'b0000;
    wword      = wdata;
    load_data  = '0;
    access_err = 1'b0;

    case (byte_off)
      2'd0:    byte_sel = rword[7:0];
      2'd1:    byte_sel = rword[15:8];
      2'd2:    byte_sel = rword[23:16];
      default: byte_sel = rword[31:24];
    endcase
    // addr[0] is ignored for halves: truncation of misaligned offsets.
    half_sel = byte_off[1] ? rword[31:16] : rword[15:0];

    if (is_store) begin
      case (funct3)
        F3_B: begin
          byte_en = 4'b0001 << byte_off;
          wword   = {4{wdata[7:0]}};
        end
        F3_H: begin
          byte_en = 4'b0011 << {byte_off[1], 1'b0};
          wword   = {2{wdata[15:0]}};
        end
        F3_W:    byte_en = 4'b1111;
        default: access_err = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
        F3_BU:   load_data = {24'h000000, byte_sel};
        F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
        F3_HU:   load_data = {16'h0000, half_sel};
        F3_W:    load_data = rword;
        default: access_err = 1'b1;
      endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    // funct3[1:0] is the size code for both loads and stores.
    misaligned = ((funct3[1:0] == 2'b01) && byte_off[0]) ||
                 ((funct3[1:0] == 2'b10) && (byte_off != 2'b00));
    if (misaligned) access_err = 1'b1;
`endif

    if (access_err) begin
      byte_en   = 4'b0000;
      load_data = '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder at the far end of the memory-access
// interface. Accepts one load/store at a time while idle, waits WAIT_STATES
// cycles, then commits the store (byte-enabled) or reads and extends load
// data, and returns a one-cycle rvalid / wdone / err pulse.
// Optional: DMEM_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses
// (handled in dmem_lane_unit).
//
// Handshake: a request is taken on a rising edge where ready=1 and
// read_en|write_en=1; strobes seen while ready=0 are dropped, not queued.
// write_en wins over read_en. Exactly one of rvalid/wdone/err pulses for
// one cycle per accepted request, WAIT_STATES+1 edges after acceptance.
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   read_en     load strobe
//   write_en    store strobe
//   funct3_in   RV32I width code
//   addr_in     byte address (upper bits alias)
//   wdata_in    store data
//   ready       idle, a strobe this cycle is accepted (0 during reset)
//   rdata_out   extended load data, valid with rvalid; 0 after err
//   rvalid      load response pulse
//   wdone       store completion pulse
//   err         rejected-access pulse
//   state_dbg   current FSM state (debug)
module dmem_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            read_en,
  input  logic            write_en,
  input  logic [2:0]      funct3_in,
  input  logic [XLEN-1:0] addr_in,
  input  logic [XLEN-1:0] wdata_in,
  output logic            ready,
  output logic [XLEN-1:0] rdata_out,
  output logic            rvalid,
  output logic            wdone,
  output logic            err,
  output logic [1:0]      state_dbg
);

  import rv_mem_pkg::*;

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int AW    = IDX_W + 2;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      f3_q, f3_d;
  logic            store_q, store_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;
  logic            wdone_q, wdone_d;
  logic            err_q, err_d;

  logic [IDX_W-1:0] word_idx;
  logic [XLEN-1:0]  rword;
  logic [3:0]       byte_en;
  logic [XLEN-1:0]  wword;
  logic [XLEN-1:0]  load_data;
  logic             access_err;
  logic             commit;

  // Upper address bits only alias the RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_in[XLEN-1:AW];

  assign word_idx = addr_q[AW-1:2];
  assign rword    = mem[word_idx];

  dmem_lane_unit u_lane (
    .is_store   (store_q),
    .funct3     (f3_q),
    .byte_off   (addr_q[1:0]),
    .wdata      (wdata_q),
    .rword      (rword),
    .byte_en    (byte_en),
    .wword      (wword),
    .load_data  (load_data),
    .access_err (access_err)
  );

  assign ready     = rst_n && (state_q == IDLE);
  assign rdata_out = rdata_q;
  assign rvalid    = rvalid_q;
  assign wdone     = wdone_q;
  assign err       = err_q;
  assign state_dbg = state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    f3_d     = f3_q;
    store_d  = store_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    wdone_d  = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (read_en || write_en) begin
          addr_d  = addr_in[AW-1:0];
          wdata_d = wdata_in;
          f3_d    = funct3_in;
          store_d = write_en;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        state_d = IDLE;
        if (access_err) begin
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (store_q) begin
          wdone_d = 1'b1;
        end else begin
          rvalid_d = 1'b1;
          rdata_d  = load_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      f3_q     <= 3'b000;
      store_q  <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wdone_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      f3_q     <= f3_d;
      store_q  <= store_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      wdone_q  <= wdone_d;
      err_q    <= err_d;
    end
  end

  // A reset landing on the RESP edge drops the store.
  assign commit = rst_n && (state_q == RESP) && store_q && !access_err;

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read_en, write_en;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in, wdata_in;
  logic        ready;
  logic [31:0] rdata_out;
  logic        rvalid, wdone, err;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(WS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .read_en   (read_en),
    .write_en  (write_en),
    .funct3_in (funct3_in),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .ready     (ready),
    .rdata_out (rdata_out),
    .rvalid    (rvalid),
    .wdone     (wdone),
    .err       (err),
    .state_dbg (state_dbg)
  );

  localparam logic [2:0] K_NONE = 3'b000;
  localparam logic [2:0] K_RV   = 3'b100;
  localparam logic [2:0] K_WD   = 3'b010;
  localparam logic [2:0] K_ERR  = 3'b001;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  kind;
    logic [31:0] rdata;
    string       name;
  } vec_t;

  vec_t vecs[$];

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, expv);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one request when ready, then measures latency and checks the
  // response pulse, rdata_out, and that the pulse lasts one cycle.
  task automatic do_access(input vec_t v);
    int  lat;
    bit  got;
    logic [31:0] exp_rd;
    lat = 0;
    while (!ready && lat < 20) begin @(negedge clk); lat++; end
    check({v.name, "_ready"}, {31'd0, ready}, 32'd1);
    read_en = v.rd; write_en = v.wr; funct3_in = v.f3;
    addr_in = v.addr; wdata_in = v.wdata;
    @(negedge clk);
    read_en = 1'b0; write_en = 1'b0;
    lat = 1; got = 0;
    while (lat < 20 && !got) begin
      if (rvalid || wdone || err) got = 1;
      else begin @(negedge clk); lat++; end
    end
    check({v.name, "_latency"}, lat, WS + 2);
    check({v.name, "_kind"}, {29'd0, rvalid, wdone, err}, {29'd0, v.kind});
    exp_q.push_back(v.rdata);
    exp_rd = exp_q.pop_front();
    check({v.name, "_rdata"}, rdata_out, exp_rd);
    @(negedge clk);
    check({v.name, "_pulse_end"}, {29'd0, rvalid, wdone, err}, 32'd0);
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [2:0] kind, input logic [31:0] rdv,
                              input string name);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.kind = kind; v.rdata = rdv; v.name = name;
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int acc_idx[$];
    int pulses;
    int lat;

    rst_n = 1'b0; read_en = 1'b0; write_en = 1'b0;
    funct3_in = 3'b000; addr_in = '0; wdata_in = '0;
    @(negedge clk); @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_pulses", {29'd0, rvalid, wdone, err}, 32'd0);
    check("rst_rdata", rdata_out, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, ready}, 32'd1);

    // Directed vectors; rdata column is rdata_out expected at the pulse
    // (it holds across stores and clears on err).
    vecs.push_back(mk(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, K_WD, 32'h0,        "sw_10"));
    vecs.push_back(mk(1, 0, 3'b010, 32'h10, 32'h0,        K_RV, 32'hDEADBEEF, "lw_10"));
    vecs.push_back(mk(0, 1, 3'b010, 32'h10, 32'h11223344, K_WD, 32'hDEADBEEF, "sw_10b"));
    vecs.push_back(mk(0, 1, 3'b000, 32'h13, 32'h00000080, K_WD, 32'hDEADBEEF, "sb_13"));
    vecs.push_back(mk(1, 0, 3'b010, 32'h10, 32'h0,        K_RV, 32'h80223344, "lw_10c"));
    vecs.push_back(mk(1, 0, 3'b000, 32'h13, 32'h0,        K_RV, 32'hFFFFFF80, "lb_13"));
    vecs.push_back(mk(1, 0, 3'b100, 32'h13, 32'h0,        K_RV, 32'h00000080, "lbu_13"));
    vecs.push_back(mk(1, 0, 3'b000, 32'h10, 32'h0,        K_RV, 32'h00000044, "lb_10"));
    vecs.push_back(mk(1, 0, 3'b100, 32'h11, 32'h0,        K_RV, 32'h00000033, "lbu_11"));
    vecs.push_back(mk(1, 0, 3'b001, 32'h10, 32'h0,        K_RV, 32'h00003344, "lh_10"));
    vecs.push_back(mk(0, 1, 3'b010, 32'h20, 32'hAAAA5555, K_WD, 32'h00003344, "sw_20"));
    vecs.push_back(mk(0, 1, 3'b001, 32'h22, 32'h00008001, K_WD, 32'h00003344, "sh_22"));
    vecs.push_back(mk(1, 0, 3'b001, 32'h22, 32'h0,        K_RV, 32'hFFFF8001, "lh_22"));
    vecs.push_back(mk(1, 0, 3'b101, 32'h22, 32'h0,        K_RV, 32'h00008001, "lhu_22"));
    vecs.push_back(mk(1, 0, 3'b101, 32'h20, 32'h0,        K_RV, 32'h00005555, "lhu_20"));
    vecs.push_back(mk(1, 0, 3'b011, 32'h10, 32'h0,        K_ERR, 32'h0,       "ld_f3_011"));
    vecs.push_back(mk(1, 0, 3'b010, 32'h20, 32'h0,        K_RV, 32'h80015555, "lw_20"));
    vecs.push_back(mk(0, 1, 3'b011, 32'h10, 32'hFFFFFFFF, K_ERR, 32'h0,       "st_f3_011"));
    vecs.push_back(mk(1, 0, 3'b010, 32'h10, 32'h0,        K_RV, 32'h80223344, "lw_10_kept"));
    vecs.push_back(mk(1, 1, 3'b010, 32'h30, 32'h12345678, K_WD, 32'h80223344, "rdwr_30"));
    vecs.push_back(mk(1, 0, 3'b010, 32'h30, 32'h0,        K_RV, 32'h12345678, "lw_30"));
    vecs.push_back(mk(1, 0, 3'b010, 32'h1030, 32'h0,      K_RV, 32'h12345678, "lw_alias"));
    vecs.push_back(mk(0, 1, 3'b010, 32'h40, 32'hCAFEF00D, K_WD, 32'h12345678, "sw_40"));

    foreach (vecs[i]) do_access(vecs[i]);

    // Reset during WAIT of SW 0x40: store dropped, no wdone.
    check("mid_ready", {31'd0, ready}, 32'd1);
    write_en = 1'b1; funct3_in = 3'b010; addr_in = 32'h40; wdata_in = 32'h0BADBEEF;
    @(negedge clk);
    write_en = 1'b0;
    check("mid_state_wait", {30'd0, state_dbg}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", {31'd0, ready}, 32'd0);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rvalid || wdone || err) pulses++;
    end
    check("mid_no_pulse", pulses, 0);
    check("mid_rdata_cleared", rdata_out, 32'd0);
    do_access(mk(1, 0, 3'b010, 32'h40, 32'h0, K_RV, 32'hCAFEF00D, "lw_40_prestore"));

    // Misaligned accesses.
`ifdef DMEM_MISALIGN_TRAP_EN
    do_access(mk(1, 0, 3'b010, 32'h41, 32'h0, K_ERR, 32'h0, "lw_41_trap"));
    do_access(mk(0, 1, 3'b001, 32'h41, 32'h1111, K_ERR, 32'h0, "sh_41_trap"));
    do_access(mk(1, 0, 3'b010, 32'h40, 32'h0, K_RV, 32'hCAFEF00D, "lw_40_after"));
`else
    do_access(mk(1, 0, 3'b010, 32'h41, 32'h0, K_RV, 32'hCAFEF00D, "lw_41_trunc"));
    do_access(mk(1, 0, 3'b001, 32'h41, 32'h0, K_RV, 32'hFFFFF00D, "lh_41_trunc"));
`endif

    // Back-to-back: read_en held high, accepts must be WS+2 cycles apart.
    read_en = 1'b1; funct3_in = 3'b010; addr_in = 32'h30;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      if (ready) acc_idx.push_back(c);
      @(negedge clk);
      if (rvalid) pulses++;
    end
    read_en = 1'b0;
    check("b2b_accepts", acc_idx.size(), 4);
    if (acc_idx.size() >= 3) begin
      check("b2b_gap1", acc_idx[1] - acc_idx[0], WS + 2);
      check("b2b_gap2", acc_idx[2] - acc_idx[1], WS + 2);
    end
    check("b2b_rdata", rdata_out, 32'h12345678);
    lat = 0;
    while (!ready && lat < 20) begin @(negedge clk); lat++; end
    check("b2b_drain", {31'd0, ready}, 32'd1);
    check("b2b_pulses", pulses, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
